adc_joy_scan: RTL and testbench

Scan sequencer that sits directly upstream and downstream of the on-chip modular ADC. It drives the ADC's Avalon-ST command interface and consumes its response stream. It alternately samples the joystick X and Y channels and averages 2^AVG_SHIFT conversions per axis. It publishes filtered 12-bit positions plus a one-hot Pac-Man direction to the game logic.

---
 rtl/adc_joy_scan_if.sv | 24 ++
 rtl/adc_joy_scan.sv | 181 ++++++++++++++++++
 tb/tb_adc_joy_scan.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_joy_scan_if.sv
// Avalon-ST command/response bundle between the joystick scan sequencer and the modular ADC.
// The scan sequencer is the master: it sources commands and sinks responses.
interface adc_joy_scan_if;
  logic        cmd_valid;
  logic [4:0]  cmd_channel;
  logic        cmd_sop;
  logic        cmd_eop;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;
  logic        rsp_sop;
  logic        rsp_eop;

  modport master (
    output cmd_valid, cmd_channel, cmd_sop, cmd_eop,
    input  cmd_ready, rsp_valid, rsp_channel, rsp_data, rsp_sop, rsp_eop
  );

  modport slave (
    input  cmd_valid, cmd_channel, cmd_sop, cmd_eop,
    output cmd_ready, rsp_valid, rsp_channel, rsp_data, rsp_sop, rsp_eop
  );
endinterface

// File: rtl/adc_joy_scan.sv
// Joystick scan sequencer: alternately converts X and Y on the modular ADC, averages
// 2^AVG_SHIFT samples per axis and publishes filtered positions plus a one-hot direction.
module adc_joy_scan #(
  parameter int CH_X      = 1,
  parameter int CH_Y      = 2,
  parameter int SCAN_DIV  = 50000,
  parameter int AVG_SHIFT = 2,
  parameter int CENTER    = 2048,
  parameter int DEADBAND  = 512,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  adc_joy_scan_if.master       adc,
  output logic [11:0]          x_val,
  output logic [11:0]          y_val,
  output logic [3:0]           dir,
  output logic                 sample_stb,
  output logic [7:0]           err_cnt
);

  localparam int TW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int OW  = $clog2(TIMEOUT + 1);
  localparam int NW  = AVG_SHIFT + 1;
  localparam int AW  = 12 + AVG_SHIFT;

  localparam logic [TW-1:0]      TICK_LAST    = TW'(SCAN_DIV - 1);
  localparam logic [OW-1:0]      TIMEOUT_LAST = OW'(TIMEOUT - 1);
  localparam logic [NW-1:0]      N_TARGET     = NW'(1 << AVG_SHIFT);
  localparam logic [4:0]         CHX          = 5'(CH_X);
  localparam logic [4:0]         CHY          = 5'(CH_Y);
  localparam logic [11:0]        CENTER_U     = 12'(CENTER);
  localparam logic signed [12:0] CENTER_S     = 13'(CENTER);
  localparam logic [12:0]        DEADBAND_U   = 13'(DEADBAND);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT, S_NEXT, S_UPDATE} state_t;

  state_t         r_state;
  logic [TW-1:0]  r_tickCnt;
  logic           r_tick;
  logic           r_cmdValid;
  logic [4:0]     r_cmdChan;
  logic           r_axisY;
  logic [AW-1:0]  r_acc;
  logic [NW-1:0]  r_n;
  logic [OW-1:0]  r_timer;
  logic [11:0]    r_yNew;

  logic [4:0]          w_chan;
  logic                w_rspHit;
  logic [AW-1:0]       w_accSum;
  logic [NW-1:0]       w_nNext;
  logic [11:0]         w_avg;
  logic signed [12:0]  w_dx, w_dy;
  logic [12:0]         w_ax, w_ay;
  logic                w_actX, w_actY;
  logic [3:0]          w_dir;
  logic                w_unusedSopEop;

  assign adc.cmd_valid   = r_cmdValid;
  assign adc.cmd_sop     = r_cmdValid;
  assign adc.cmd_eop     = r_cmdValid;
  assign adc.cmd_channel = r_cmdChan;
  assign w_unusedSopEop  = adc.rsp_sop ^ adc.rsp_eop;

  assign w_chan   = r_axisY ? CHY : CHX;
  assign w_rspHit = adc.rsp_valid && (adc.rsp_channel == w_chan);
  assign w_accSum = r_acc + AW'(adc.rsp_data);
  assign w_nNext  = r_n + 1'b1;
  assign w_avg    = 12'(r_acc >> AVG_SHIFT);

  // Direction is judged on the committed X and the freshly averaged Y, so y_val and dir land together.
  assign w_dx   = $signed({1'b0, x_val}) - CENTER_S;
  assign w_dy   = $signed({1'b0, r_yNew}) - CENTER_S;
  assign w_ax   = w_dx[12] ? 13'(-w_dx) : 13'(w_dx);
  assign w_ay   = w_dy[12] ? 13'(-w_dy) : 13'(w_dy);
  assign w_actX = w_ax > DEADBAND_U;
  assign w_actY = w_ay > DEADBAND_U;

  always_comb begin
    w_dir = 4'b0000;
    if (w_actX && (!w_actY || (w_ax >= w_ay)))
      w_dir = w_dx[12] ? 4'b0010 : 4'b0001;
    else if (w_actY)
      w_dir = w_dy[12] ? 4'b0100 : 4'b1000;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_tickCnt <= '0;
      r_tick    <= 1'b0;
    end else if (r_tickCnt == TICK_LAST) begin
      r_tickCnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_tickCnt <= r_tickCnt + 1'b1;
      r_tick    <= 1'b0;
    end
  end

  // Ticks that arrive outside IDLE are simply ignored; a slow scan just skips a period.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state    <= S_IDLE;
      r_cmdValid <= 1'b0;
      r_cmdChan  <= CHX;
      r_axisY    <= 1'b0;
      r_acc      <= '0;
      r_n        <= '0;
      r_timer    <= '0;
      r_yNew     <= CENTER_U;
      x_val      <= CENTER_U;
      y_val      <= CENTER_U;
      dir        <= 4'b0000;
      sample_stb <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      sample_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_tick) begin
            r_axisY    <= 1'b0;
            r_acc      <= '0;
            r_n        <= '0;
            r_cmdValid <= 1'b1;
            r_cmdChan  <= CHX;
            r_state    <= S_CMD;
          end
        end
        S_CMD: begin
          if (adc.cmd_ready) begin
            r_cmdValid <= 1'b0;
            r_timer    <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_rspHit) begin
            r_acc <= w_accSum;
            r_n   <= w_nNext;
            if (w_nNext == N_TARGET) begin
              r_state <= S_NEXT;
            end else begin
              r_cmdValid <= 1'b1;
              r_state    <= S_CMD;
            end
          end else if (r_timer == TIMEOUT_LAST) begin
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 1'b1;
            r_cmdValid <= 1'b1;
            r_state    <= S_CMD;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_NEXT: begin
          if (!r_axisY) begin
            x_val      <= w_avg;
            r_axisY    <= 1'b1;
            r_acc      <= '0;
            r_n        <= '0;
            r_cmdValid <= 1'b1;
            r_cmdChan  <= CHY;
            r_state    <= S_CMD;
          end else begin
            r_yNew  <= w_avg;
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          y_val      <= r_yNew;
          dir        <= w_dir;
          sample_stb <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_joy_scan.sv
// Self-checking bench: a behavioural ADC answers commands from per-channel data queues and a
// scoreboard compares every sample_stb against averages/directions computed from the rules.
module tb_adc_joy_scan;
  localparam int SCAN_DIV  = 64;
  localparam int AVG_SHIFT = 2;
  localparam int TIMEOUT   = 32;
  localparam int CENTER    = 2048;
  localparam int DEADBAND  = 512;
  localparam int NAVG      = 4;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [11:0] x_val, y_val;
  logic [3:0]  dir;
  logic        sample_stb;
  logic [7:0]  err_cnt;

  always #5 clk_clk = ~clk_clk;

  adc_joy_scan_if bus ();

  adc_joy_scan #(
    .CH_X(1), .CH_Y(2), .SCAN_DIV(SCAN_DIV), .AVG_SHIFT(AVG_SHIFT),
    .CENTER(CENTER), .DEADBAND(DEADBAND), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .adc(bus.master),
    .x_val(x_val),
    .y_val(y_val),
    .dir(dir),
    .sample_stb(sample_stb),
    .err_cnt(err_cnt)
  );

  typedef struct { int x; int y; logic [3:0] d; int err; } exp_t;
  typedef struct { int due; int ch; int data; } rsp_t;

  exp_t expQ[$];
  rsp_t pendQ[$];
  int   xq[$], yq[$];
  int   cmdLog[$];
  int   checks = 0, errors = 0;
  int   stbCount = 0, scanStart = 0, errExp = 0, stallReq = 0, adcCycle = 0;
  int   prevCh = 0;
  bit   withholdX = 0, withheld = 0, prevWait = 0, prevStb = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] refDir(input int x, input int y);
    int dx, dy, ax, ay;
    dx = x - CENTER;
    dy = y - CENTER;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    if (ax > DEADBAND && (ay <= DEADBAND || ax >= ay)) return (dx > 0) ? 4'b0001 : 4'b0010;
    if (ay > DEADBAND) return (dy > 0) ? 4'b1000 : 4'b0100;
    return 4'b0000;
  endfunction

  // Queue one scan's worth of ADC data and the result the game logic should then see.
  task automatic applyStimulus(input int xs[4], input int ys[4], input bit withhold, input int stall);
    exp_t e;
    int sx = 0, sy = 0;
    for (int i = 0; i < NAVG; i++) begin
      xq.push_back(xs[i]);
      yq.push_back(ys[i]);
      sx += xs[i];
      sy += ys[i];
    end
    if (withhold) errExp++;
    e.x = sx / NAVG;
    e.y = sy / NAVG;
    e.d = refDir(e.x, e.y);
    e.err = errExp;
    expQ.push_back(e);
    cmdLog.delete();
    withholdX = withhold;
    withheld = 0;
    stallReq = stall;
    scanStart = stbCount;
  endtask

  task automatic awaitScan(input string name, input int nX);
    int n = 0;
    int bad = 0;
    while (stbCount == scanStart && n < 3000) begin
      @(negedge clk_clk);
      n++;
    end
    checkOutput({name, "_scan_done"}, stbCount - scanStart, 1);
    checkOutput({name, "_cmd_count"}, cmdLog.size(), nX + NAVG);
    for (int i = 0; i < cmdLog.size(); i++)
      if (cmdLog[i] != ((i < nX) ? 1 : 2)) bad++;
    checkOutput({name, "_cmd_channels"}, bad, 0);
  endtask

  // Behavioural ADC: drives ready/responses on the falling edge so the DUT samples stable values.
  always @(negedge clk_clk) begin
    rsp_t r;
    adcCycle++;
    bus.rsp_valid   = 1'b0;
    bus.rsp_sop     = 1'b0;
    bus.rsp_eop     = 1'b0;
    if (!reset_reset_n) begin
      bus.cmd_ready = 1'b0;
      prevWait = 0;
    end else begin
      if (pendQ.size() > 0 && pendQ[0].due <= adcCycle) begin
        r = pendQ.pop_front();
        bus.rsp_valid   = 1'b1;
        bus.rsp_sop     = 1'b1;
        bus.rsp_eop     = 1'b1;
        bus.rsp_channel = 5'(r.ch);
        bus.rsp_data    = 12'(r.data);
      end
      if (prevWait) begin
        checkOutput("stall_valid_stable", int'(bus.cmd_valid), 1);
        checkOutput("stall_chan_stable", int'(bus.cmd_channel), prevCh);
      end
      if (bus.cmd_valid && stallReq > 0) begin
        bus.cmd_ready = 1'b0;
        stallReq--;
      end else begin
        bus.cmd_ready = 1'b1;
      end
      prevWait = bus.cmd_valid && !bus.cmd_ready;
      prevCh   = int'(bus.cmd_channel);
      if (bus.cmd_valid && bus.cmd_ready) begin
        cmdLog.push_back(int'(bus.cmd_channel));
        if (withholdX && bus.cmd_channel == 5'd1) begin
          withholdX = 0;
          withheld = 1;
          r.due = adcCycle + 3; r.ch = 5; r.data = int'($urandom_range(0, 4095));
          pendQ.push_back(r);
        end else if ((bus.cmd_channel == 5'd1 && xq.size() == 0) ||
                     (bus.cmd_channel == 5'd2 && yq.size() == 0) ||
                     (bus.cmd_channel != 5'd1 && bus.cmd_channel != 5'd2)) begin
          checkOutput("adc_cmd_has_data", 0, 1);
        end else begin
          r.ch = int'(bus.cmd_channel);
          r.data = (bus.cmd_channel == 5'd1) ? xq.pop_front() : yq.pop_front();
          r.due = adcCycle + int'($urandom_range(1, 4));
          pendQ.push_back(r);
        end
      end
    end
  end

  // Scoreboard monitor: every strobe retires the oldest expected scan.
  always @(negedge clk_clk) begin
    exp_t e;
    if (reset_reset_n) begin
      if (bus.cmd_valid)
        checkOutput("sop_eop", int'({bus.cmd_sop, bus.cmd_eop}), 3);
      if (sample_stb) begin
        stbCount++;
        checkOutput("stb_one_cycle", int'(prevStb), 0);
        if (expQ.size() == 0) begin
          checkOutput("stb_expected", 0, 1);
        end else begin
          e = expQ.pop_front();
          checkOutput("x_val", int'(x_val), e.x);
          checkOutput("y_val", int'(y_val), e.y);
          checkOutput("dir", int'(dir), int'(e.d));
          checkOutput("err_cnt", int'(err_cnt), e.err);
        end
      end
      prevStb = sample_stb;
    end else begin
      prevStb = 0;
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_valid"}, int'(bus.cmd_valid), 0);
    checkOutput({tag, "_cmd_channel"}, int'(bus.cmd_channel), 1);
    checkOutput({tag, "_x_val"}, int'(x_val), CENTER);
    checkOutput({tag, "_y_val"}, int'(y_val), CENTER);
    checkOutput({tag, "_dir"}, int'(dir), 0);
    checkOutput({tag, "_sample_stb"}, int'(sample_stb), 0);
    checkOutput({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    int xs[4], ys[4];
    int n;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_channel = 5'd0;
    bus.rsp_data = 12'd0;
    bus.rsp_sop = 1'b0;
    bus.rsp_eop = 1'b0;

    repeat (3) @(negedge clk_clk);
    checkResetValues("reset");

    xs = '{3000, 3001, 3002, 3003};
    ys = '{2048, 2048, 2048, 2048};
    applyStimulus(xs, ys, 0, 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    n = 0;
    while (!bus.cmd_valid && n < 200) begin
      @(negedge clk_clk);
      n++;
    end
    checkOutput("first_cmd_latency", n, SCAN_DIV + 1);
    checkOutput("first_cmd_channel", int'(bus.cmd_channel), 1);
    awaitScan("average", NAVG);

    xs = '{2560, 2560, 2560, 2560};
    applyStimulus(xs, ys, 0, 0);
    awaitScan("deadband", NAVG);

    xs = '{0, 0, 0, 0};
    ys = '{4095, 4095, 4095, 4095};
    applyStimulus(xs, ys, 0, 0);
    awaitScan("tie", NAVG);

    for (int i = 0; i < NAVG; i++) begin
      xs[i] = int'($urandom_range(0, 4095));
      ys[i] = int'($urandom_range(0, 4095));
    end
    applyStimulus(xs, ys, 0, 10);
    awaitScan("stall", NAVG);
    checkOutput("stall_consumed", stallReq, 0);

    xs = '{1000, 1100, 1200, 1300};
    for (int i = 0; i < NAVG; i++) ys[i] = int'($urandom_range(0, 4095));
    applyStimulus(xs, ys, 1, 0);
    n = 0;
    while (!withheld && n < 500) begin
      @(negedge clk_clk);
      n++;
    end
    checkOutput("withhold_seen", int'(withheld), 1);
    repeat (20) @(negedge clk_clk);
    checkOutput("err_before_timeout", int'(err_cnt), errExp - 1);
    repeat (20) @(negedge clk_clk);
    checkOutput("err_after_timeout", int'(err_cnt), errExp);
    awaitScan("timeout", NAVG + 1);

    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < NAVG; i++) begin
        xs[i] = (s % 2 == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(1400, 2700));
        ys[i] = (s % 3 == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(1400, 2700));
      end
      applyStimulus(xs, ys, 0, int'($urandom_range(0, 3)));
      awaitScan("random", NAVG);
    end

    xs = '{500, 510, 520, 530};
    ys = '{3900, 3900, 3900, 3900};
    applyStimulus(xs, ys, 0, 0);
    n = 0;
    while (cmdLog.size() < NAVG + 1 && n < 2000) begin
      @(negedge clk_clk);
      n++;
    end
    checkOutput("reached_y_phase", int'(cmdLog.size() >= NAVG + 1), 1);
    @(posedge clk_clk);
    #2 reset_reset_n = 1'b0;
    #1 checkResetValues("midscan_reset");
    xq.delete();
    yq.delete();
    pendQ.delete();
    expQ.delete();
    errExp = 0;
    stallReq = 0;
    withholdX = 0;
    repeat (3) @(negedge clk_clk);
    xs = '{1700, 1800, 1900, 2000};
    ys = '{100, 200, 300, 400};
    applyStimulus(xs, ys, 0, 0);
    reset_reset_n = 1'b1;
    awaitScan("post_reset", NAVG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
